// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: registered request fields from the stage,
// single-cycle ack and read data back from memory.
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one req/ack data-memory transaction per load/store,
// aligns/extends load data and produces a registered writeback slot.
module mem_access_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [31:0]         regcData_i,
   input  logic [4:0]          regcAddr_i,
   input  logic                regcWr_i,
   input  logic [31:0]         memAddr_i,
   input  logic [31:0]         memData_i,
   input  logic                readWr_i,
   input  logic                writeWr_i,
   input  logic [3:0]          rmask_i,
   input  logic [3:0]          wmask_i,
   input  logic                sext_i,
   mem_access_stage_if.master  dmem,
   output logic                wb_valid,
   output logic [31:0]         wb_data,
   output logic [4:0]          wb_addr,
   output logic                wb_wr,
   output logic                err_o
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   function automatic logic mask_ok(input logic [3:0] m);
      case (m)
         4'b0000, 4'b1111, 4'b0011, 4'b1100,
         4'b0001, 4'b0010, 4'b0100, 4'b1000: mask_ok = 1'b1;
         default:                            mask_ok = 1'b0;
      endcase
   endfunction

   // Replicating the low byte/half onto every lane lets the strobe pick the lane.
   function automatic logic [31:0] lane_wdata(input logic [3:0] m, input logic [31:0] d);
      case (m)
         4'b1111:          lane_wdata = d;
         4'b0011, 4'b1100: lane_wdata = {2{d[15:0]}};
         default:          lane_wdata = {4{d[7:0]}};
      endcase
   endfunction

   function automatic logic [31:0] load_align(input logic [3:0] m, input logic sx,
                                              input logic [31:0] r);
      logic [7:0]  b;
      logic [15:0] h;
      b = m[0] ? r[7:0] : m[1] ? r[15:8] : m[2] ? r[23:16] : r[31:24];
      h = m[3] ? r[31:16] : r[15:0];
      case (m)
         4'b1111:                            load_align = r;
         4'b0011, 4'b1100:                   load_align = {{16{sx & h[15]}}, h};
         4'b0001, 4'b0010, 4'b0100, 4'b1000: load_align = {{24{sx & b[7]}}, b};
         default:                            load_align = 32'h0;
      endcase
   endfunction

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               req_r, we_r;
   logic [31:0]        addr_r, wdata_r;
   logic [3:0]         wstrb_r;

   logic [4:0]         regc_addr_p1;
   logic               regc_wr_p1;
   logic [3:0]         rmask_p1;
   logic               sext_p1;

   logic               accept, mem_op, bad_mask;
   logic [3:0]         act_mask;
   logic               unused_addr_lo;

   // Sub-word position is carried entirely by the lane masks.
   assign unused_addr_lo = ^memAddr_i[1:0];

   assign accept   = valid_i & ready_o;
   assign mem_op   = readWr_i | writeWr_i;
   assign act_mask = writeWr_i ? wmask_i : rmask_i;
   assign bad_mask = mem_op & ~mask_ok(act_mask);

   assign dmem.dmem_req   = req_r;
   assign dmem.dmem_we    = we_r;
   assign dmem.dmem_addr  = addr_r;
   assign dmem.dmem_wdata = wdata_r;
   assign dmem.dmem_wstrb = wstrb_r;

   // p0 -> p1: instruction fields needed only when the memory response returns
   always_ff @(posedge clk) begin
      if (accept && mem_op && !bad_mask) begin
         regc_addr_p1 <= regcAddr_i;
         regc_wr_p1   <= regcWr_i;
         rmask_p1     <= rmask_i;
         sext_p1      <= sext_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ready_o  <= 1'b1;
         cnt      <= '0;
         req_r    <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= 32'h0;
         wdata_r  <= 32'h0;
         wstrb_r  <= 4'h0;
         wb_valid <= 1'b0;
         wb_data  <= 32'h0;
         wb_addr  <= 5'h0;
         wb_wr    <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         err_o    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (!mem_op) begin
                     wb_valid <= 1'b1;
                     wb_data  <= regcData_i;
                     wb_addr  <= regcAddr_i;
                     wb_wr    <= regcWr_i;
                  end else if (bad_mask) begin
                     err_o <= 1'b1;
                  end else begin
                     state   <= S_WAIT;
                     ready_o <= 1'b0;
                     cnt     <= '0;
                     req_r   <= 1'b1;
                     we_r    <= writeWr_i;
                     addr_r  <= {memAddr_i[31:2], 2'b00};
                     wdata_r <= writeWr_i ? lane_wdata(wmask_i, memData_i) : 32'h0;
                     wstrb_r <= writeWr_i ? wmask_i : 4'h0;
                  end
               end
            end
            S_WAIT: begin
               // Ack is checked first so a response on the last allowed cycle still completes.
               if (dmem.dmem_ack) begin
                  state    <= S_IDLE;
                  ready_o  <= 1'b1;
                  req_r    <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_addr  <= regc_addr_p1;
                  wb_wr    <= we_r ? 1'b0 : regc_wr_p1;
                  wb_data  <= we_r ? 32'h0 : load_align(rmask_p1, sext_p1, dmem.dmem_rdata);
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  state   <= S_IDLE;
                  ready_o <= 1'b1;
                  req_r   <= 1'b0;
                  err_o   <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               ready_o <= 1'b1;
               req_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writeback/error events are queued
// at issue time and matched against wb_valid/err_o pulses by a monitor.
module tb_mem_access_stage;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, ready_o;
   logic [31:0] regcData_i, memAddr_i, memData_i;
   logic [4:0]  regcAddr_i;
   logic        regcWr_i, readWr_i, writeWr_i, sext_i;
   logic [3:0]  rmask_i, wmask_i;
   logic        wb_valid, wb_wr, err_o;
   logic [31:0] wb_data;
   logic [4:0]  wb_addr;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
      .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWr_i(regcWr_i),
      .memAddr_i(memAddr_i), .memData_i(memData_i), .readWr_i(readWr_i),
      .writeWr_i(writeWr_i), .rmask_i(rmask_i), .wmask_i(wmask_i), .sext_i(sext_i),
      .dmem(bus), .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
      .wb_wr(wb_wr), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          err;
      logic [31:0] data;
      logic [4:0]  addr;
      logic        wr;
      bit          care_addr;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_wb(input logic [31:0] d, input logic [4:0] a, input logic w,
                          input bit care_a);
      exp_t e;
      e.err = 1'b0; e.data = d; e.addr = a; e.wr = w; e.care_addr = care_a;
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.err = 1'b1; e.data = 32'h0; e.addr = 5'h0; e.wr = 1'b0; e.care_addr = 1'b0;
      sb.push_back(e);
   endtask

   // Monitor: every writeback or error pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && (wb_valid || err_o)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'h0, wb_valid, err_o}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_kind", {30'h0, wb_valid, err_o}, e.err ? 32'h1 : 32'h2);
            if (!e.err) begin
               check("wb_data", wb_data, e.data);
               check("wb_wr", {31'h0, wb_wr}, {31'h0, e.wr});
               if (e.care_addr) check("wb_addr", {27'h0, wb_addr}, {27'h0, e.addr});
            end
         end
      end
   end

   task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] rm, input logic [3:0] wm,
                        input logic sx, input logic [31:0] regc, input logic [4:0] ra,
                        input logic rw);
      @(negedge clk);
      check("ready_at_issue", {31'h0, ready_o}, 32'h1);
      valid_i = 1'b1; readWr_i = rd; writeWr_i = wr; memAddr_i = addr; memData_i = data;
      rmask_i = rm; wmask_i = wm; sext_i = sx; regcData_i = regc; regcAddr_i = ra;
      regcWr_i = rw;
   endtask

   task automatic idle();
      @(negedge clk);
      valid_i = 1'b0; readWr_i = 1'b0; writeWr_i = 1'b0;
      memAddr_i = $urandom; memData_i = $urandom; regcData_i = $urandom;
   endtask

   // Memory responder: ack is raised in the ack_after-th cycle that req is high.
   task automatic serve(input int ack_after, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic exp_we,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
      check("req_start", {31'h0, bus.dmem_req}, 32'h1);
      check("ready_low", {31'h0, ready_o}, 32'h0);
      check("dmem_addr", bus.dmem_addr, exp_addr);
      check("dmem_we", {31'h0, bus.dmem_we}, {31'h0, exp_we});
      check("dmem_wstrb", {28'h0, bus.dmem_wstrb}, {28'h0, exp_wstrb});
      if (exp_we) check("dmem_wdata", bus.dmem_wdata, exp_wdata);
      for (int n = 1; n < ack_after; n++) begin
         @(negedge clk);
         check("req_hold", {31'h0, bus.dmem_req}, 32'h1);
         check("addr_hold", bus.dmem_addr, exp_addr);
      end
      bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
      @(negedge clk);
      bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
      check("req_drop", {31'h0, bus.dmem_req}, 32'h0);
      check("ready_back", {31'h0, ready_o}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      rst = 1'b1; valid_i = 0; readWr_i = 0; writeWr_i = 0; memAddr_i = 0; memData_i = 0;
      rmask_i = 0; wmask_i = 0; sext_i = 0; regcData_i = 0; regcAddr_i = 0; regcWr_i = 0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", {31'h0, ready_o}, 32'h1);
      check("rst_req", {31'h0, bus.dmem_req}, 32'h0);
      check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_err", {31'h0, err_o}, 32'h0);

      // ALU op, then three back-to-back ALU ops
      push_wb(32'h1234, 5'd3, 1'b1, 1'b1);
      issue(0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 32'h1234, 5'd3, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         push_wb(32'h1111 * i, 5'(i + 8), i[0], 1'b1);
         issue(0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 32'h1111 * i, 5'(i + 8), i[0]);
      end
      idle();

      // LW, ack on the third request cycle
      push_wb(32'hDEADBEEF, 5'd5, 1'b1, 1'b1);
      issue(1, 0, 32'h100, 32'h0, 4'b1111, 4'h0, 0, 32'h0, 5'd5, 1'b1);
      idle();
      serve(3, 32'hDEADBEEF, 32'h100, 1'b0, 32'h0, 4'h0);

      // LB lane 3 signed / unsigned
      push_wb(32'hFFFFFF80, 5'd6, 1'b1, 1'b1);
      issue(1, 0, 32'h103, 32'h0, 4'b1000, 4'h0, 1, 32'h0, 5'd6, 1'b1);
      idle();
      serve(1, 32'h80123456, 32'h100, 1'b0, 32'h0, 4'h0);
      push_wb(32'h00000080, 5'd7, 1'b1, 1'b1);
      issue(1, 0, 32'h103, 32'h0, 4'b1000, 4'h0, 0, 32'h0, 5'd7, 1'b1);
      idle();
      serve(2, 32'h80123456, 32'h100, 1'b0, 32'h0, 4'h0);

      // LH upper signed, LB lane 1 unsigned with wb_wr=0
      push_wb(32'hFFFF8001, 5'd8, 1'b1, 1'b1);
      issue(1, 0, 32'h202, 32'h0, 4'b1100, 4'h0, 1, 32'h0, 5'd8, 1'b1);
      idle();
      serve(1, 32'h8001_7F00, 32'h200, 1'b0, 32'h0, 4'h0);
      push_wb(32'h000000A5, 5'd9, 1'b0, 1'b1);
      issue(1, 0, 32'h301, 32'h0, 4'b0010, 4'h0, 0, 32'h0, 5'd9, 1'b0);
      idle();
      serve(1, 32'h0000A5FF, 32'h300, 1'b0, 32'h0, 4'h0);

      // SH upper half, SB lane 2
      push_wb(32'h0, 5'd0, 1'b0, 1'b0);
      issue(0, 1, 32'h102, 32'h0000ABCD, 4'h0, 4'b1100, 0, 32'h0, 5'd10, 1'b1);
      idle();
      serve(2, 32'h0, 32'h100, 1'b1, 32'hABCDABCD, 4'b1100);
      push_wb(32'h0, 5'd0, 1'b0, 1'b0);
      issue(0, 1, 32'h406, 32'h12345655, 4'h0, 4'b0100, 0, 32'h0, 5'd11, 1'b1);
      idle();
      serve(1, 32'h0, 32'h404, 1'b1, 32'h55555555, 4'b0100);

      // Load and store together: store wins, illegal rmask is ignored
      push_wb(32'h0, 5'd0, 1'b0, 1'b0);
      issue(1, 1, 32'h500, 32'hCAFEF00D, 4'b0101, 4'b1111, 1, 32'h0, 5'd12, 1'b1);
      idle();
      serve(1, 32'hFFFFFFFF, 32'h500, 1'b1, 32'hCAFEF00D, 4'b1111);

      // Ack on the very cycle the counter reaches TIMEOUT: completes, no error
      push_wb(32'h13579BDF, 5'd13, 1'b1, 1'b1);
      issue(1, 0, 32'h600, 32'h0, 4'b1111, 4'h0, 0, 32'h0, 5'd13, 1'b1);
      idle();
      serve(TIMEOUT + 1, 32'h13579BDF, 32'h600, 1'b0, 32'h0, 4'h0);

      // Timeout: no ack, req abandoned, error pulse, late ack ignored
      push_err();
      issue(1, 0, 32'h700, 32'h0, 4'b1111, 4'h0, 0, 32'h0, 5'd14, 1'b1);
      idle();
      n = 0;
      while (bus.dmem_req && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("timeout_req_cycles", n, TIMEOUT + 1);
      check("timeout_ready", {31'h0, ready_o}, 32'h1);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h11111111;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      check("late_ack_req", {31'h0, bus.dmem_req}, 32'h0);
      check("late_ack_wb", {31'h0, wb_valid}, 32'h0);

      // Illegal load mask: error, no request
      push_err();
      issue(1, 0, 32'h800, 32'h0, 4'b0101, 4'h0, 0, 32'h0, 5'd15, 1'b1);
      idle();
      check("badmask_req", {31'h0, bus.dmem_req}, 32'h0);
      check("badmask_ready", {31'h0, ready_o}, 32'h1);

      // Reset while waiting
      issue(1, 0, 32'h900, 32'h0, 4'b1111, 4'h0, 0, 32'h0, 5'd16, 1'b1);
      idle();
      check("pre_rst_req", {31'h0, bus.dmem_req}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_req", {31'h0, bus.dmem_req}, 32'h0);
      check("midrst_ready", {31'h0, ready_o}, 32'h1);
      check("midrst_wb_data", wb_data, 32'h0);
      check("midrst_wb_addr", {27'h0, wb_addr}, 32'h0);
      check("midrst_dmem_addr", bus.dmem_addr, 32'h0);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h22222222;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      check("postrst_ack_wb", {31'h0, wb_valid}, 32'h0);
      check("postrst_ack_req", {31'h0, bus.dmem_req}, 32'h0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
